// File: rtl/cobra_loader_pkg.sv
// ============================================================================
// Module      : cobra_loader_pkg
// Description : Shared constants for the CYBERcobra program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cobra_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 8;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_LEN   = 3'd1;
    localparam logic [ST_W-1:0] S_DATA  = 3'd2;
    localparam logic [ST_W-1:0] S_WRITE = 3'd3;
    localparam logic [ST_W-1:0] S_CSUM  = 3'd4;
    localparam logic [ST_W-1:0] S_ERR   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/cobra_loader_timeout.sv
// ============================================================================
// Module      : cobra_loader_timeout
// Description : Clearable saturating idle counter with expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cobra_loader_timeout #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic CLK,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);

    localparam int              c_CW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT_CYC);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_expired = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/cobra_prog_loader.sv
// ============================================================================
// Module      : cobra_prog_loader
// Description : Framed byte-stream loader writing the core's instruction RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cobra_prog_loader
    import cobra_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [IMEM_AW-1:0] mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [IMEM_AW:0]   r_count;
    logic [IMEM_AW:0]   r_waddr;
    logic [1:0]         r_idx;
    logic [7:0]         r_csum;
    logic [INSTR_W-1:0] r_word;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_err;

    logic w_acc;
    logic w_run;
    logic w_expired;
    logic w_last_word;

    assign w_acc       = in_valid && in_ready;
    assign w_run       = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_last_word = ((r_waddr + 9'd1) == r_count);

    cobra_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK       (CLK),
        .rst       (rst),
        .i_run     (w_run),
        .i_clr     (w_acc || !w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An accepted byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && (in_data == SYNC_BYTE)) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_acc)          w_state_nxt = S_DATA;
                else if (w_expired) w_state_nxt = S_ERR;
            end
            S_DATA: begin
                if (w_acc) begin
                    if (r_idx == 2'd3) w_state_nxt = S_WRITE;
                end else if (w_expired) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                w_state_nxt = w_last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_acc)          w_state_nxt = (in_data == r_csum) ? S_IDLE : S_ERR;
                else if (w_expired) w_state_nxt = S_ERR;
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b1;
        mem_we   = 1'b0;
        if (r_state == S_WRITE) begin
            in_ready = 1'b0;
            mem_we   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_waddr   <= '0;
            r_idx     <= '0;
            r_csum    <= '0;
            r_word    <= '0;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && (in_data == SYNC_BYTE)) begin
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_acc) begin
                        r_count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        r_waddr <= '0;
                        r_idx   <= '0;
                        r_csum  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_word[{r_idx, 3'b000} +: 8] <= in_data;
                        r_csum                       <= r_csum + in_data;
                        r_idx                        <= r_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_waddr <= r_waddr + 9'd1;
                end
                S_CSUM: begin
                    if (w_acc && (in_data == r_csum)) begin
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b0;
                    end
                end
                S_ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The 9-bit counter reaches 256 after a full-size frame; hold the bus at 255.
    assign mem_addr  = r_waddr[IMEM_AW] ? {IMEM_AW{1'b1}} : r_waddr[IMEM_AW-1:0];
    assign mem_wdata = r_word;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire
